uart_cmd_decoder: RTL and testbench
===================================

// Module: uart_cmd_decoder
// PURPOSE
//   Consumes bytes from the UART receiver and assembles 4-byte command packets:
//   HEADER, CMD, ARG, CHK, with CHK = CMD ^ ARG. Valid packets update the car's
//   motion direction and speed registers for the motion controller.
//   Bad packets (byte error, bad checksum, inter-byte timeout) are dropped and counted.
//   Runs on the receiver's clk_16x domain; no CDC inside.
// PARAMETERS
//   HEADER         8'hAA      packet start byte
//   TIMEOUT        16'd40000  max clk_16x cycles between bytes inside a packet
//   SPEED_DEFAULT  8'd128     speed value after reset
// PORTS
//   clk_16x     in   1   clock (16x baud sample clock)
//   rst         in   1   asynchronous reset, active-high
//   rx_data     in   8   received byte; stable while rx_ready=1
//   rx_ready    in   1   level; a 0->1 transition marks one new byte
//   rx_error    in   1   sampled with the accepted byte; 1 = byte corrupt
//   cmd_valid   out  1   1-cycle pulse per accepted packet
//   cmd_code    out  8   CMD of last accepted packet
//   cmd_arg     out  8   ARG of last accepted packet
//   move_dir    out  3   0 stop, 1 fwd, 2 back, 3 left, 4 right
//   speed       out  8   current speed setpoint
//   err_cnt     out  8   dropped-packet counter, saturates at 8'hFF
//   busy        out  1   1 while state != S_IDLE
// BEHAVIOUR
//   Reset (async, any time, incl. mid-packet):
//     - state=S_IDLE, rdy_d=0
//     - cmd_valid=0, cmd_code=0, cmd_arg=0, move_dir=0, speed=SPEED_DEFAULT
//     - err_cnt=0, busy=0, timer=0
//   Byte accept:
//     - rdy_d <= rx_ready every cycle
//     - acc = rx_ready & ~rdy_d; byte/err captured on that edge
//     - rx_ready held high = one byte only
//   FSM (advances only on acc unless noted):
//     - S_IDLE: byte==HEADER & !rx_error -> S_CMD; any other byte ignored
//       (no count, no error)
//     - S_CMD: latch cmd_r -> S_ARG
//     - S_ARG: latch arg_r -> S_CHK
//     - S_CHK: compare byte to cmd_r^arg_r; always -> S_IDLE
//     - Inside S_CMD/S_ARG/S_CHK, HEADER value is ordinary data (no resync)
//   Errors (from S_CMD, S_ARG or S_CHK -> S_IDLE, err_cnt += 1 saturating):
//     - rx_error=1 on accepted byte
//     - checksum mismatch
//     - timer reaches TIMEOUT
//   Timer:
//     - cleared on every acc and in S_IDLE, else +1
//     - acc and timer==TIMEOUT in same cycle: acc wins, no timeout
//   Good packet, on the edge that accepts CHK:
//     - cmd_code<=cmd_r, cmd_arg<=arg_r
//     - cmd_valid=1 for exactly the following cycle (1-cycle latency from CHK acc)
//     - CMD 0x00-0x04: move_dir<=CMD[2:0]
//     - CMD 0x05: speed<=ARG (0 legal)
//     - other CMD: cmd_valid still pulses, move_dir/speed unchanged, no error
//   Outputs are registered; move_dir/speed hold until the next valid packet or reset.
// TESTING
//   - Reset, feed AA 01 00 01 -> cmd_valid 1 cycle after CHK acc; move_dir=1,
//     cmd_code=01, err_cnt=0
//   - AA 05 40 45 -> speed=8'h40, move_dir unchanged; then AA 05 00 05 -> speed=0
//   - AA 02 00 03 (bad chk) -> no cmd_valid, err_cnt=1, move_dir held;
//     next AA 02 00 02 -> move_dir=2
//   - AA 03 then silence TIMEOUT+1 cycles -> busy=0, err_cnt+1;
//     byte arriving exactly at TIMEOUT -> accepted, no error
//   - rx_ready held high for 3 bytes' time -> one byte only;
//     ARG with rx_error=1 -> abort, err_cnt+1; 300 bad packets -> err_cnt=FF
//   - Assert rst while in S_ARG -> all outputs at reset values at once;
//     post-reset AA 04 00 04 -> move_dir=4

Source files
------------

// File: rtl/uart_cmd_decoder.sv
`timescale 1ns/1ps
// UART command packet decoder: assembles HEADER/CMD/ARG/CHK packets into
// motion direction and speed setpoints, counting dropped packets.
module uart_cmd_decoder #(
  parameter logic [7:0]  HEADER        = 8'hAA,
  parameter logic [15:0] TIMEOUT       = 16'd40000,
  parameter logic [7:0]  SPEED_DEFAULT = 8'd128
) (
  input  logic       clk_16x,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_error,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic [2:0] move_dir,
  output logic [7:0] speed,
  output logic [7:0] err_cnt,
  output logic       busy
);
  localparam logic [7:0] CMD_DIR_MAX = 8'h04;
  localparam logic [7:0] CMD_SPEED   = 8'h05;
  localparam logic [7:0] ERR_MAX     = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ARG, S_CHK} state_t;

  state_t      state;
  logic        rdy_d;
  logic [15:0] timer;
  logic [7:0]  cmd_r;
  logic [7:0]  arg_r;
  logic        acc_c;
  logic        drop_c;
  logic        good_c;

  assign acc_c = rx_ready & ~rdy_d;

  // Packet outcome; an accepted byte takes priority over a coincident timeout.
  always_comb begin
    drop_c = 1'b0;
    good_c = 1'b0;
    if (state != S_IDLE) begin
      if (acc_c) begin
        if (rx_error) begin
          drop_c = 1'b1;
        end else if (state == S_CHK) begin
          if (rx_data == (cmd_r ^ arg_r)) good_c = 1'b1;
          else                            drop_c = 1'b1;
        end
      end else if (timer == TIMEOUT) begin
        drop_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_16x or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rdy_d     <= 1'b0;
      timer     <= 16'd0;
      cmd_r     <= 8'd0;
      arg_r     <= 8'd0;
      cmd_valid <= 1'b0;
      cmd_code  <= 8'd0;
      cmd_arg   <= 8'd0;
      move_dir  <= 3'd0;
      speed     <= SPEED_DEFAULT;
      err_cnt   <= 8'd0;
      busy      <= 1'b0;
    end else begin
      rdy_d     <= rx_ready;
      cmd_valid <= 1'b0;
      timer     <= (state == S_IDLE || acc_c) ? 16'd0 : timer + 16'd1;
      if (drop_c) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 8'd1;
      end else if (good_c) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        cmd_valid <= 1'b1;
        cmd_code  <= cmd_r;
        cmd_arg   <= arg_r;
        if (cmd_r <= CMD_DIR_MAX)    move_dir <= cmd_r[2:0];
        else if (cmd_r == CMD_SPEED) speed    <= arg_r;
      end else if (acc_c) begin
        case (state)
          S_IDLE: begin
            if (rx_data == HEADER && !rx_error) begin
              state <= S_CMD;
              busy  <= 1'b1;
            end
          end
          S_CMD: begin
            cmd_r <= rx_data;
            state <= S_ARG;
          end
          S_ARG: begin
            arg_r <= rx_data;
            state <= S_CHK;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for uart_cmd_decoder against a byte-stream packet model.
module tb_uart_cmd_decoder;
  localparam int TO  = 200;
  localparam logic [7:0] HDR = 8'hAA;
  localparam logic [7:0] SPD_DEF = 8'd128;

  logic       clk_16x = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_ready = 1'b0;
  logic       rx_error = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_code, cmd_arg, speed, err_cnt;
  logic [2:0] move_dir;
  logic       busy;

  uart_cmd_decoder #(.HEADER(HDR), .TIMEOUT(16'(TO)), .SPEED_DEFAULT(SPD_DEF)) dut (
    .clk_16x(clk_16x), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_error(rx_error), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_arg(cmd_arg), .move_dir(move_dir), .speed(speed),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk_16x = ~clk_16x;

  int cyc = 0;
  always @(posedge clk_16x) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] code;
    logic [7:0] arg;
    logic [2:0] dir;
    logic [7:0] spd;
    logic [7:0] err;
    int         edge_n;
  } exp_t;
  exp_t sb[$];

  // Reference model: packet-level view of the accepted byte stream
  bit         m_in = 0;
  logic [7:0] m_bytes[$];
  logic [2:0] m_dir = 3'd0;
  logic [7:0] m_spd = SPD_DEF;
  logic [7:0] m_err = 8'd0;
  logic [7:0] m_code = 8'd0;
  logic [7:0] m_arg = 8'd0;
  int         last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void bump();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endfunction

  function automatic void model_reset();
    m_in = 0; m_bytes.delete();
    m_dir = 3'd0; m_spd = SPD_DEF; m_err = 8'd0; m_code = 8'd0; m_arg = 8'd0;
  endfunction

  function automatic void model_accept(input logic [7:0] d, input logic e, input int edge_n);
    exp_t x;
    if (m_in && (edge_n - last_acc > TO + 1)) begin m_in = 0; bump(); end
    if (!m_in) begin
      if (d == HDR && !e) begin m_in = 1; m_bytes.delete(); end
    end else if (e) begin
      m_in = 0; bump();
    end else begin
      m_bytes.push_back(d);
      if (m_bytes.size() == 3) begin
        m_in = 0;
        if ((m_bytes[0] ^ m_bytes[1]) == m_bytes[2]) begin
          m_code = m_bytes[0]; m_arg = m_bytes[1];
          if (m_code < 8'd5) m_dir = m_code[2:0];
          else if (m_code == 8'd5) m_spd = m_arg;
          x.code = m_code; x.arg = m_arg; x.dir = m_dir; x.spd = m_spd;
          x.err = m_err; x.edge_n = edge_n;
          sb.push_back(x);
        end else begin
          bump();
        end
      end
    end
    last_acc = edge_n;
  endfunction

  // Present one byte so that its rising rx_ready is seen `gap` edges after the previous accept
  task automatic send_at(input logic [7:0] d, input logic e, input int gap, input int hold);
    int target;
    target = last_acc + gap;
    @(posedge clk_16x); #1;
    while (cyc < target - 1) begin @(posedge clk_16x); #1; end
    rx_data = d; rx_error = e; rx_ready = 1'b1;
    model_accept(d, e, cyc + 1);
    repeat (hold) @(posedge clk_16x);
    #1 rx_ready = 1'b0; rx_error = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic e);
    send_at(d, e, $urandom_range(0, 6), $urandom_range(1, 3));
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send_b(HDR, 1'b0); send_b(c, 1'b0); send_b(a, 1'b0); send_b(k, 1'b0);
  endtask

  // Let the line go quiet (past any pending timeout) and compare state against the model
  task automatic check_idle(input string tag);
    if (m_in) begin
      while (cyc < last_acc + TO + 2) @(posedge clk_16x);
      if (m_in) begin m_in = 0; bump(); end
    end
    repeat (3) @(posedge clk_16x);
    @(negedge clk_16x);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_move_dir"}, 32'(move_dir), 32'(m_dir));
    chk({tag, "_speed"}, 32'(speed), 32'(m_spd));
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every cmd_valid cycle must match the next expected packet
  always @(negedge clk_16x) begin
    if (!rst && cmd_valid) begin
      if (sb.size() == 0) begin
        chk("cmd_valid_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("valid_latency", 32'(cyc), 32'(x.edge_n));
        chk("cmd_code", 32'(cmd_code), 32'(x.code));
        chk("cmd_arg", 32'(cmd_arg), 32'(x.arg));
        chk("pkt_move_dir", 32'(move_dir), 32'(x.dir));
        chk("pkt_speed", 32'(speed), 32'(x.spd));
        chk("pkt_err_cnt", 32'(err_cnt), 32'(x.err));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_16x);
    #1;
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_move_dir", 32'(move_dir), 32'd0);
    chk("rst_speed", 32'(speed), 32'(SPD_DEF));
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_code", 32'(cmd_code), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk_16x);

    send_pkt(8'h01, 8'h00, 8'h01);
    check_idle("fwd");
    chk("fwd_dir_const", 32'(move_dir), 32'd1);

    send_pkt(8'h05, 8'h40, 8'h45);
    check_idle("speed40");
    chk("speed40_const", 32'(speed), 32'h40);
    send_pkt(8'h05, 8'h00, 8'h05);
    check_idle("speed0");

    send_pkt(8'h02, 8'h00, 8'h03);
    check_idle("badchk");
    chk("badchk_err_const", 32'(err_cnt), 32'd1);
    send_pkt(8'h02, 8'h00, 8'h02);
    check_idle("back");

    send_b(HDR, 1'b0); send_b(8'h03, 1'b0);
    check_idle("timeout");

    // byte landing on the timeout edge is accepted; one edge later is not
    send_b(HDR, 1'b0);
    send_at(8'h03, 1'b0, TO + 1, 1);
    send_at(8'h00, 1'b0, TO + 1, 1);
    send_at(8'h03, 1'b0, TO + 1, 1);
    check_idle("to_edge_ok");
    send_b(HDR, 1'b0); send_b(8'h04, 1'b0);
    send_at(8'h00, 1'b0, TO + 2, 1);
    check_idle("to_edge_late");

    send_at(HDR, 1'b0, 2, 48);
    send_b(8'h01, 1'b0); send_b(8'h00, 1'b0); send_b(8'h01, 1'b0);
    check_idle("held_ready");

    send_b(HDR, 1'b0); send_b(8'h01, 1'b0); send_b(8'h00, 1'b1); send_b(8'h01, 1'b0);
    check_idle("arg_err");

    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [7:0] c, a;
      kind = $urandom_range(0, 9);
      c = 8'($urandom_range(0, 7));
      a = 8'($urandom);
      case (kind)
        0: send_b(8'($urandom), 1'b0);
        1: send_pkt(c, a, (c ^ a) ^ 8'($urandom_range(1, 255)));
        2: begin
          int p;
          p = $urandom_range(0, 3);
          send_b(HDR, p == 0); send_b(c, p == 1); send_b(a, p == 2); send_b(c ^ a, p == 3);
        end
        3: begin
          send_b(HDR, 1'b0); send_b(c, 1'b0);
          send_at(a, 1'b0, TO + int'($urandom_range(0, 3)), 1);
          send_b(c ^ a, 1'b0);
        end
        default: send_pkt(c, a, c ^ a);
      endcase
    end
    check_idle("random");

    for (int i = 0; i < 300; i++) send_pkt(8'h00, 8'h00, 8'h01);
    check_idle("saturate");
    chk("saturate_const", 32'(err_cnt), 32'hFF);

    send_pkt(8'h03, 8'h00, 8'h03);
    check_idle("pre_reset");
    send_b(HDR, 1'b0); send_b(8'h04, 1'b0);
    @(posedge clk_16x); #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_move_dir", 32'(move_dir), 32'd0);
    chk("midrst_speed", 32'(speed), 32'(SPD_DEF));
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_cmd_code", 32'(cmd_code), 32'd0);
    chk("midrst_cmd_arg", 32'(cmd_arg), 32'd0);
    repeat (2) @(posedge clk_16x);
    #1 rst = 1'b0;
    send_pkt(8'h04, 8'h00, 8'h04);
    check_idle("post_reset");
    chk("post_reset_dir_const", 32'(move_dir), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
